// File: rtl/fetch_decode_pkg.sv
// Shared state encoding and opcode constants for the fetch/decode sequencer.
// Pure declarations: no latency, no flow control.
package fetch_decode_pkg;

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_EXECUTE = 2'd1;
  localparam logic [1:0] ST_HALT    = 2'd2;

  // Opcodes with bit 3 set carry an immediate operand in IR[3:0].
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_OUT = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_ADI = 4'h9;
  localparam logic [3:0] OP_SBI = 4'hA;
  localparam logic [3:0] HLT_OP = 4'hF;

  localparam int IMM_BIT = 3;

  function automatic logic op_uses_imm(input logic [3:0] op);
    return op[IMM_BIT];
  endfunction

  function automatic logic state_is_phase1(input logic [1:0] st);
    return (st == ST_EXECUTE) || (st == ST_HALT);
  endfunction

endpackage

// File: rtl/fetch_decode_pc_counter.sv
// Program counter: load beats increment, increment wraps modulo 2^W.
// One-edge latency; inc/load are qualified by the caller, so no stall logic here.
module pc_counter #(
  parameter int W = 12
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_decode.sv
// Two-phase fetch/execute sequencer: FETCH latches IR and bumps pc, EXECUTE may jump or halt.
// One instruction per two enabled edges; enable low freezes every register.
module fetch_decode #(
  parameter int         PC_W   = 12,
  parameter logic [3:0] HLT_OP = fetch_decode_pkg::HLT_OP
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            load_pc,
  input  logic [PC_W-1:0] jump_addr,
  input  logic [7:0]      program_byte,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      instr,
  output logic [3:0]      oprnd,
  output logic            imm_sel,
  output logic            phase,
  output logic            halted
);

  import fetch_decode_pkg::*;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] ir;
  logic       in_fetch;
  logic       in_exec;
  logic       is_hlt;
  logic       pc_inc;
  logic       pc_load;

  assign in_fetch = (state == ST_FETCH);
  assign in_exec  = (state == ST_EXECUTE);
  assign is_hlt   = (ir[7:4] == HLT_OP);

  // A halt opcode suppresses any jump requested in the same EXECUTE.
  assign pc_inc  = enable && in_fetch;
  assign pc_load = enable && in_exec && !is_hlt && load_pc;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: begin
        if (enable) state_nxt = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (enable) state_nxt = is_hlt ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH;
      ir    <= 8'h00;
    end else begin
      state <= state_nxt;
      if (pc_inc) ir <= program_byte;
    end
  end

  pc_counter #(
    .W (PC_W)
  ) u_pc (
    .clock    (clock),
    .reset    (reset),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (jump_addr),
    .count    (pc)
  );

  assign instr   = ir[7:4];
  assign oprnd   = ir[3:0];
  assign imm_sel = op_uses_imm(ir[7:4]) && in_exec;
  assign phase   = state_is_phase1(state);
  assign halted  = (state == ST_HALT);

endmodule
